// File: rtl/rv_pkg.sv
// Shared RV32I definitions used across the fetch path.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous queue of fetched {instr, pc} entries with flush and occupancy count.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Flush voids both the push and the pop of the same cycle.
  assign do_pop  = pop && !flush && (cnt != '0);
  assign do_push = push && !flush && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: owns the PC, issues credit-limited word reads,
// buffers responses for decode and handles redirects by dropping stale responses.
module ifetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] tgt_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   occ;
  logic            req_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign tgt_pc = {PCTarget[XLEN-1:2], 2'b00};

  // Credits cover both buffered words and words still in flight.
  assign imem_req_valid = !reset && ((SW'(occ) + SW'(outstanding)) < SW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && (drop == '0) && !PCSrc;
  assign pop  = instr_valid && instr_ready && !PCSrc;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign push_entry = '{instr: imem_rsp_data, pc: enq_pc};

  // Every word still in flight after a redirect belongs to the old stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      enq_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (PCSrc) begin
        fetch_pc <= tgt_pc;
        enq_pc   <= tgt_pc;
        drop     <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     enq_pc   <= enq_pc + 32'd4;
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (PCSrc),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (occ)
  );

  assign instr_valid = (occ != '0);
  assign Instr       = instr_valid ? head.instr : NOP_INSTR;
  assign PC          = instr_valid ? head.pc : '0;
  assign PCPlus4     = instr_valid ? head.pc + 32'd4 : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: in-order latency memory model, stream-level
// reference (expected PC sequences), directed tables and sequences, then random traffic.
module tb_ifetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_w;
  logic [31:0] pc_w;
  logic [31:0] pc4_w;

  ifetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .PCSrc          (PCSrc),
    .PCTarget       (PCTarget),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .Instr          (instr_w),
    .PC             (pc_w),
    .PCPlus4        (pc4_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t pend[$];

  typedef struct {
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[6];

  int lat = 1;
  int rdy_pct = 100;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int idle = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic        after_redir = 1'b0;
  logic        auto_redir = 1'b0;
  logic        auto_hit = 1'b0;

  logic        o_rv, o_fire, o_iv, o_pop, o_rsp;
  logic [31:0] o_addr, o_pc, o_pc4, o_instr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory returns word ~addr, so any mis-tagged or stale word shows up in Instr.
  task automatic cycle(input logic ir, input logic ps, input logic [31:0] tgt);
    instr_ready    = ir;
    PCSrc          = ps;
    PCTarget       = tgt;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~pend[0].addr;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (auto_redir && instr_valid && imem_rsp_valid) begin
      PCSrc      = 1'b1;
      auto_redir = 1'b0;
      auto_hit   = 1'b1;
    end
    o_rv    = imem_req_valid;
    o_fire  = imem_req_valid && imem_req_ready;
    o_addr  = imem_req_addr;
    o_iv    = instr_valid;
    o_pc    = pc_w;
    o_pc4   = pc4_w;
    o_instr = instr_w;
    o_rsp   = imem_rsp_valid;
    o_pop   = instr_valid && instr_ready && !PCSrc;

    if (after_redir) chk("flushed_after_redirect", 32'(instr_valid), 32'd0);
    if (o_rv) chk("req_addr", o_addr, exp_req);
    if (o_fire) chk("credit_bound", 32'(pend.size() < DEPTH), 32'd1);
    if (o_iv) begin
      chk("pc", o_pc, exp_pc);
      chk("pc_plus4", o_pc4, exp_pc + 32'd4);
      chk("instr", o_instr, ~exp_pc);
    end else begin
      chk("empty_instr", o_instr, NOP);
      chk("empty_pc", o_pc, 32'd0);
      chk("empty_pcplus4", o_pc4, 32'd0);
    end
    if (instr_ready && !o_pop) idle++;
    else idle = 0;
    chk("stall_budget", 32'(idle > 40), 32'd0);
    if (idle > 40) idle = 0;

    if (o_fire) exp_req = exp_req + 32'd4;
    if (o_pop)  exp_pc  = exp_pc + 32'd4;
    if (PCSrc) begin
      exp_req = PCTarget & ~32'd3;
      exp_pc  = PCTarget & ~32'd3;
    end
    after_redir = PCSrc;

    if (imem_rsp_valid) void'(pend.pop_front());
    if (o_fire) pend.push_back('{addr: o_addr, due: cyc + lat});
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    PCSrc          = 1'b0;
    instr_ready    = 1'b0;
    pend.delete();
    #1;
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset_instr_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr", instr_w, NOP);
    chk("reset_pc", pc_w, 32'd0);
    repeat (2) @(negedge clk);
    lat         = l;
    exp_pc      = RPC;
    exp_req     = RPC;
    after_redir = 1'b0;
    auto_redir  = 1'b0;
    idle        = 0;
    reset       = 1'b0;
  endtask

  initial begin
    int fires;
    int rsp_cnt;
    int first_req;
    int first_pc;
    logic seen_a, seen_b;
    logic [31:0] r;
    logic ir, ps;

    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    PCSrc = 1'b0; PCTarget = '0; instr_ready = 1'b0;
    exp_pc = RPC; exp_req = RPC;
    @(negedge clk);

    // Start-up sequence after reset, 1-cycle memory, decode always ready.
    tbl[0] = '{ir: 1'b1, rv: 1'b1, addr: 32'h100, iv: 1'b0, pc: 32'h0};
    tbl[1] = '{ir: 1'b1, rv: 1'b1, addr: 32'h104, iv: 1'b0, pc: 32'h0};
    tbl[2] = '{ir: 1'b1, rv: 1'b0, addr: 32'h108, iv: 1'b1, pc: 32'h100};
    tbl[3] = '{ir: 1'b1, rv: 1'b1, addr: 32'h108, iv: 1'b1, pc: 32'h104};
    tbl[4] = '{ir: 1'b1, rv: 1'b1, addr: 32'h10C, iv: 1'b0, pc: 32'h0};
    tbl[5] = '{ir: 1'b1, rv: 1'b0, addr: 32'h110, iv: 1'b1, pc: 32'h108};
    rdy_pct = 100;
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].ir, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_req_valid", i), 32'(o_rv), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_req_addr", i), o_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_instr_valid", i), 32'(o_iv), 32'(tbl[i].iv));
      chk($sformatf("tbl%0d_pc", i), o_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_pc_plus4", i), o_pc4, tbl[i].iv ? tbl[i].pc + 32'd4 : 32'd0);
      chk($sformatf("tbl%0d_instr", i), o_instr, tbl[i].iv ? ~tbl[i].pc : NOP);
    end

    // Backpressure: decode stalled, credits run out after DEPTH requests.
    do_reset(1);
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (o_fire) fires++;
    end
    chk("bp_req_count", 32'(fires), 32'(DEPTH));
    chk("bp_req_valid_held_low", 32'(o_rv), 32'd0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("bp_release_pc0", o_pc, 32'h100);
    cycle(1'b1, 1'b0, 32'h0);
    chk("bp_release_pc1", o_pc, 32'h104);
    repeat (10) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset(3);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h2002);
    first_req = -1; first_pc = -1; rsp_cnt = 0;
    for (int i = 0; i < 20 && first_pc < 0; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (o_fire && first_req < 0) first_req = int'(o_addr);
      if (o_iv) first_pc = int'(o_pc);
      else if (o_rsp) rsp_cnt++;
    end
    chk("redir_first_req", 32'(first_req), 32'h2000);
    chk("redir_first_pc", 32'(first_pc), 32'h2000);
    chk("redir_dropped", 32'(rsp_cnt - 1), 32'd2);

    // Redirect coinciding with a response and a pop.
    do_reset(1);
    auto_hit = 1'b0; auto_redir = 1'b1;
    for (int i = 0; i < 10 && !auto_hit; i++) cycle(1'b1, 1'b0, 32'h3000);
    chk("simul_hit", 32'(auto_hit), 32'd1);
    auto_redir = 1'b0;
    cycle(1'b1, 1'b0, 32'h0);
    chk("simul_flushed", 32'(o_iv), 32'd0);
    first_pc = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (o_iv && first_pc < 0) first_pc = int'(o_pc);
    end
    chk("simul_first_pc", 32'(first_pc), 32'h3000);

    // Asynchronous reset with a full queue.
    do_reset(1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    chk("midrst_queue_filled", 32'(o_iv), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", instr_w, NOP);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    do_reset(2);
    cycle(1'b1, 1'b0, 32'h0);
    chk("midrst_restart_valid", 32'(o_rv), 32'd1);
    chk("midrst_restart_addr", o_addr, RPC);

    // PC wrap-around from the top of the address space.
    do_reset(1);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFE);
    seen_a = 1'b0; seen_b = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (o_iv && o_pc == 32'hFFFF_FFFC && o_pc4 == 32'h0) seen_a = 1'b1;
      if (o_iv && o_pc == 32'h0 && seen_a) seen_b = 1'b1;
    end
    chk("wrap_head_pcplus4", 32'(seen_a), 32'd1);
    chk("wrap_next_pc", 32'(seen_b), 32'd1);

    // Random traffic against the stream-level model.
    rdy_pct = 70;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset(1 + seg % 3);
      for (int i = 0; i < 500; i++) begin
        r  = $urandom;
        ir = ($urandom_range(99) < 60);
        ps = ($urandom_range(99) < 4);
        cycle(ir, ps, ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | (r & 32'hF)) : r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
